// File: rtl/fifo_rd_adapter_pkg.sv
// fifo_rd_adapter_pkg
// Shared constants and helpers for the FIFO reader adapter and its skid buffer.
// The skid buffer holds at most two words, so every occupancy sum fits in
// three bits and is compared against SKID_LIMIT.
package fifo_rd_adapter_pkg;

  // Occupancy value of a completely full skid buffer.
  localparam logic [1:0] SKID_FULL  = 2'd2;

  // Committed-word limit used by the read-issue logic (3-bit form).
  localparam logic [2:0] SKID_LIMIT = 3'd2;

  // True when the words already committed to the buffer leave room for one more.
  function automatic logic has_room(input logic [2:0] committed);
    return committed < SKID_LIMIT;
  endfunction

endpackage

// File: rtl/fifo_rd_adapter_skid.sv
// fifo_rd_adapter_skid
// Two-entry ordered buffer. It is built as a shift structure: head_q is
// always the oldest word and drives data_o directly, and tail_q is the
// second-oldest word.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push_i     write data_i into the buffer this cycle
//   data_i     word to push
//   pop_i      consumer takes the head word this cycle
//   valid_o    registered, buffer not empty
//   data_o     registered head word (0 after reset)
//   occ_o      words currently held (0..2)
module fifo_rd_adapter_skid
  import fifo_rd_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  valid_q, valid_d;

  // Next-state logic. A pop shifts the tail into the head. A push lands in
  // the first free slot. When a push and a pop happen together at occ=2, the
  // tail moves forward and the new word takes its place, so order is kept.
  // A push at occ=2 without a pop cannot happen, because the read-issue
  // logic never commits more than two words.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = data_i;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = data_i;
          occ_d  = SKID_FULL;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == SKID_FULL) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: ;
    endcase
    valid_d = (occ_d != 2'd0);
  end

  // State registers. valid_q is kept as its own flop so that out_valid comes
  // straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter
// Drains the read port of a team fifo and presents the words as a
// valid/ready stream with registered outputs. Set LOOKAHEAD to match the
// attached fifo:
//   0: fifo_dout is valid in the cycle after fifo_rd.
//   1: fifo_dout shows the head word whenever the fifo is not empty.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   fifo_empty   fifo empty flag
//   fifo_rd      combinational read/pop strobe to the fifo
//   fifo_dout    fifo read data
//   out_valid    registered, stream word available
//   out_ready    consumer accepts the word (may depend on out_valid)
//   out_data     registered stream word, the skid buffer head
//   occupancy    words held in the skid buffer (0..2)
module fifo_rd_adapter
  import fifo_rd_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit LOOKAHEAD  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic       pop;
  logic       push;
  logic [2:0] committed;

  assign pop = out_valid && out_ready;

  // "committed" counts the words that will be in the buffer after this
  // cycle's pop. A new read is issued only if that count leaves room, so
  // the buffer can never overflow. The sum is 3 bits wide so it cannot wrap.
  generate
    if (LOOKAHEAD == 1'b0) begin : g_registered_read
      logic inflight_q;

      assign committed = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
      assign push      = inflight_q;

      // A read that was issued last cycle delivers its word now. Reset
      // clears this flag, which discards any word still in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          inflight_q <= 1'b0;
        end else begin
          inflight_q <= fifo_rd;
        end
      end
    end else begin : g_lookahead_read
      assign committed = {1'b0, occupancy} - {2'b00, pop};
      assign push      = fifo_rd;
    end
  endgenerate

  assign fifo_rd = !rst && !fifo_empty && has_room(committed);

  fifo_rd_adapter_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (fifo_dout),
    .pop_i  (pop),
    .valid_o(out_valid),
    .data_o (out_data),
    .occ_o  (occupancy)
  );

endmodule

// File: doc/fifo_rd_adapter.md
Name: fifo_rd_adapter

Overview:
Reader-side adapter for the team's `fifo` block. It drains a FIFO read port (`empty`/`rd`/`dout`) and presents the data as a valid/ready stream with registered outputs. It works with either FIFO read flavour, selected by LOOKAHEAD, and sustains one word per cycle through a 2-entry skid buffer. It sits between any `fifo` instance and a downstream stream consumer.

Parameters:
- DATA_WIDTH, 32, width of FIFO word and stream data.
- LOOKAHEAD, 0, must match the attached FIFO.
  - 0: `fifo_dout` is valid the cycle after `fifo_rd`.
  - 1: `fifo_dout` shows the head word whenever `!fifo_empty`; `fifo_rd` pops it.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  FIFO read/pop strobe; combinational.
- fifo_dout  input  DATA_WIDTH  FIFO read data.
- out_valid  output  1  stream word available; registered.
- out_ready  input  1  consumer accepts the word; may depend on `out_valid`.
- out_data  output  DATA_WIDTH  stream data; registered, equals the buffer head.
- occupancy  output  2  words currently held in the skid buffer (0..2).

Behaviour:
- Reset: buffer is cleared (occ=0, inflight=0). `out_valid`=0, `out_data`=0, `occupancy`=0, `fifo_rd`=0 while `rst`=1.
- Reset mid-operation: any inflight read data is discarded, buffer contents are dropped. The FIFO is assumed reset on the same `rst`.
- pop = `out_valid && out_ready`.
- Read issue, LOOKAHEAD=0:
  - `fifo_rd` = `!rst && !fifo_empty && (occ + inflight - pop) < 2`.
  - inflight is a register: inflight <= `fifo_rd`.
  - The word on `fifo_dout` is pushed into the buffer in the cycle where inflight=1.
- Read issue, LOOKAHEAD=1:
  - `fifo_rd` = `!rst && !fifo_empty && (occ - pop) < 2`.
  - `fifo_dout` is pushed in the same cycle `fifo_rd`=1; inflight is always 0.
- Buffer: 2-entry, strict FIFO order, with head/tail pointers or an equivalent shift structure.
  - A push and a pop in the same cycle keep occ unchanged and preserve ordering.
  - A push at occ=2 without a pop is impossible by construction. The bench asserts it never occurs.
- Outputs: `out_valid` = (occ != 0), `out_data` = head word; both come from registers.
  - `out_data` must be held stable while `out_valid && !out_ready`.
  - `out_data` may be don't-care when `out_valid`=0, but is 0 after reset.
- Latency, first word after `fifo_empty` falls at cycle T:
  - LOOKAHEAD=0: `fifo_rd` at T, push at T+1, `out_valid` at T+2.
  - LOOKAHEAD=1: `fifo_rd` and push at T, `out_valid` at T+1.
- Throughput: with `out_ready` held at 1 and the FIFO non-empty, one word per cycle in steady state. LOOKAHEAD=0 runs with occ=1, inflight=1.
- Backpressure: while `out_ready`=0, at most 2 words are read. `fifo_rd` stays 0 once occ + inflight = 2.
- Empty: `fifo_rd` never asserts while `fifo_empty`=1. A FIFO that empties mid-stream creates bubbles but never a duplicate or a dropped word.
- No arithmetic beyond 2-bit occ/inflight sums. Sums are computed in 3 bits so `occ + inflight - pop` never wraps.

Decomposition:
- No new package typedefs. LOOKAHEAD stays a plain parameter consistent with `fifo`'s own parameter.
- One sub-module: `fifo_rd_adapter_skid`, the 2-entry ordered buffer with push/pop/occ.
- The top level holds the read-issue logic, the inflight register and the LOOKAHEAD generate branches.

Test Plan:
- Steady drain (LOOKAHEAD=0 and 1): write 1..8 into `fifo`, hold `out_ready`=1 -> `out_data` sequence 1..8 on 8 consecutive `out_valid` cycles, first at T+2 (LA=0) or T+1 (LA=1).
- Backpressure: write 1..8, hold `out_ready`=0 for 10 cycles -> exactly 2 `fifo_rd` pulses, `occupancy`=2, `out_data`=1 stable. Then release -> 1..8 in order, no gaps after release.
- Random ready: 1024 words, `out_ready` = $urandom_range(0,1) every cycle, scoreboard compare -> zero mismatches, zero drops or duplicates, overflow assertion never fires.
- Sparse producer: write one word every 3 cycles with `out_ready`=1 -> each word appears exactly once, `out_valid` bubbles between, `fifo_rd` never asserts with `fifo_empty`=1.
- Reset mid-stream: assert `rst` for 1 cycle while occ=2 and inflight=1 -> next cycle `out_valid`=0, `occupancy`=0, `out_data`=0. After new writes of 9,10 -> the stream outputs 9,10 only.
- Simultaneous push/pop at occ=2 (LA=1): hold `out_ready`=1 with a full FIFO -> `occupancy` stays 2 or settles to 1, order is preserved.
